// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK levels and the default target address.
package i2c_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 7;

    localparam logic [ADDR_W-1:0] I2C_DEFAULT_ADDR = 7'b0101011;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX_BYTE,
        ST_RX_ACK,
        ST_TX_LOAD,
        ST_TX_BYTE,
        ST_TX_ACK,
        ST_IGNORE
    } i2c_state_e;

    // General call (address 0) is never claimed.
    function automatic logic addr_match(input logic [ADDR_W-1:0] rx_addr,
                                        input logic [ADDR_W-1:0] own_addr);
        return (rx_addr == own_addr) && (rx_addr != '0);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA input synchroniser with registered edge, START and STOP strobes.
// sda_lvl is the synchronised SDA level aligned with the strobes.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_lvl,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
    logic start_q, start_d, stop_q, stop_d;
    logic scl_cur, sda_cur;

    assign scl_cur = scl_sync_q[SYNC_STAGES-1];
    assign sda_cur = sda_sync_q[SYNC_STAGES-1];

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_prev_d = scl_cur;
        sda_prev_d = sda_cur;
        scl_rise_d = scl_cur & ~scl_prev_q;
        scl_fall_d = ~scl_cur & scl_prev_q;
        start_d    = scl_cur & scl_prev_q & sda_prev_q & ~sda_cur;
        stop_d     = scl_cur & scl_prev_q & ~sda_prev_q & sda_cur;
    end

    // Synchronisers preset to the idle (released) bus level.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    assign sda_lvl   = sda_prev_q;
    assign scl_rise  = scl_rise_q;
    assign scl_fall  = scl_fall_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;

endmodule

// File: rtl/i2c_slave_target.sv
// I2C target endpoint: address match, ACK, byte receive and byte transmit.
// Define I2C_SLAVE_STRETCH_EN to stretch SCL while tx_valid is low instead of sending 8'hFF.
module i2c_slave_target
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SLAVE_ADDR  = I2C_DEFAULT_ADDR,
    parameter int unsigned       SYNC_STAGES = 2
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              scl_oe,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_first,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy,
    output logic              addressed
);

    logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_in    (clk_in),
        .rst       (rst),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_lvl   (sda_lvl),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_e        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] shift_q, shift_d, rx_data_q, rx_data_d, byte_in;
    logic rw_q, rw_d, first_q, first_d, rx_pend_q, rx_pend_d, rx_fpend_q, rx_fpend_d;
    logic sda_oe_q, sda_oe_d, rx_valid_q, rx_valid_d, rx_first_q, rx_first_d;
    logic tx_ready_q, tx_ready_d, busy_q, busy_d, addressed_q, addressed_d;
`ifdef I2C_SLAVE_STRETCH_EN
    logic scl_oe_q, scl_oe_d;
`else
    logic [BYTE_W-1:0] tx_fill;
    assign tx_fill = tx_valid ? tx_data : 8'hFF;
`endif

    assign byte_in = {shift_q[BYTE_W-2:0], sda_lvl};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        first_d     = first_q;
        rx_data_d   = rx_data_q;
        rx_pend_d   = 1'b0;
        rx_fpend_d  = 1'b0;
        rx_valid_d  = rx_pend_q;
        rx_first_d  = rx_pend_q & rx_fpend_q;
        sda_oe_d    = sda_oe_q;
        tx_ready_d  = 1'b0;
        busy_d      = busy_q;
        addressed_d = addressed_q;
`ifdef I2C_SLAVE_STRETCH_EN
        scl_oe_d    = scl_oe_q;
`endif
        // Bus conditions override any bit-level activity.
        if (stop_det) begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            addressed_d = 1'b0;
            sda_oe_d    = 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
            scl_oe_d    = 1'b0;
`endif
        end else if (start_det) begin
            state_d     = ST_ADDR;
            busy_d      = 1'b1;
            addressed_d = 1'b0;
            sda_oe_d    = 1'b0;
            bit_cnt_d   = 3'd0;
`ifdef I2C_SLAVE_STRETCH_EN
            scl_oe_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rw_d    = byte_in[0];
                        first_d = 1'b1;
                        state_d = addr_match(byte_in[BYTE_W-1:1], SLAVE_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                    end
                end
                // First fall drives ACK; a read leaves at the ACK rise, a write at the next fall.
                ST_ADDR_ACK, ST_RX_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d    = 1'b1;
                            addressed_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RX_BYTE;
                        end
                    end else if (scl_rise && sda_oe_q && rw_q) begin
                        state_d = ST_TX_LOAD;
                    end
                end
                ST_RX_BYTE: if (scl_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = byte_in;
                        rx_pend_d  = 1'b1;
                        rx_fpend_d = first_q;
                        first_d    = 1'b0;
                        state_d    = ST_RX_ACK;
                    end
                end
                ST_TX_LOAD: begin
`ifdef I2C_SLAVE_STRETCH_EN
                    if ((scl_oe_q || scl_fall) && tx_valid) begin
                        shift_d    = tx_data;
                        sda_oe_d   = ~tx_data[BYTE_W-1];
                        tx_ready_d = 1'b1;
                        state_d    = ST_TX_BYTE;
                    end else if (scl_fall) begin
                        scl_oe_d = 1'b1;
                    end
`else
                    if (scl_fall) begin
                        shift_d    = tx_fill;
                        sda_oe_d   = ~tx_fill[BYTE_W-1];
                        tx_ready_d = tx_valid;
                        state_d    = ST_TX_BYTE;
                    end
`endif
                end
                ST_TX_BYTE: begin
`ifdef I2C_SLAVE_STRETCH_EN
                    scl_oe_d = 1'b0;
`endif
                    if (scl_fall) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_TX_ACK;
                        end else begin
                            sda_oe_d = ~shift_q[BYTE_W-2];
                            shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
                        end
                    end
                end
                ST_TX_ACK: if (scl_rise) begin
                    state_d = (sda_lvl == ACK) ? ST_TX_LOAD : ST_IGNORE;
                end
                ST_IDLE, ST_IGNORE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            first_q     <= 1'b0;
            rx_data_q   <= '0;
            rx_pend_q   <= 1'b0;
            rx_fpend_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_first_q  <= 1'b0;
            sda_oe_q    <= 1'b0;
            tx_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            addressed_q <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
            scl_oe_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            first_q     <= first_d;
            rx_data_q   <= rx_data_d;
            rx_pend_q   <= rx_pend_d;
            rx_fpend_q  <= rx_fpend_d;
            rx_valid_q  <= rx_valid_d;
            rx_first_q  <= rx_first_d;
            sda_oe_q    <= sda_oe_d;
            tx_ready_q  <= tx_ready_d;
            busy_q      <= busy_d;
            addressed_q <= addressed_d;
`ifdef I2C_SLAVE_STRETCH_EN
            scl_oe_q    <= scl_oe_d;
`endif
        end
    end

    assign sda_oe    = sda_oe_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_first  = rx_first_q;
    assign tx_ready  = tx_ready_q;
    assign busy      = busy_q;
    assign addressed = addressed_q;
`ifdef I2C_SLAVE_STRETCH_EN
    assign scl_oe    = scl_oe_q;
`else
    assign scl_oe    = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: bus-level master model plus transaction reference model.
module tb_i2c_slave_target;

    localparam logic [6:0] DUT_ADDR = 7'h2B;
    localparam int Q = 8;
`ifdef I2C_SLAVE_STRETCH_EN
    localparam logic [7:0] FILL = 8'h81;
    localparam bit STRETCH = 1'b1;
`else
    localparam logic [7:0] FILL = 8'hFF;
    localparam bit STRETCH = 1'b0;
`endif

    logic clk, rst;
    logic m_scl_oe, m_sda_oe;
    logic scl_bus, sda_bus;
    logic sda_oe, scl_oe, rx_valid, rx_first, tx_ready, busy, addressed, tx_valid;
    logic [7:0] rx_data, tx_data;

    assign scl_bus = ~(m_scl_oe | scl_oe);
    assign sda_bus = ~(m_sda_oe | sda_oe);

    i2c_slave_target dut (
        .clk_in    (clk),
        .rst       (rst),
        .scl_in    (scl_bus),
        .sda_in    (sda_bus),
        .sda_oe    (sda_oe),
        .scl_oe    (scl_oe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_first  (rx_first),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .addressed (addressed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int stretch_cnt = 0;
    logic [7:0] wr_plan     [8];
    logic [7:0] tx_dat_plan [8];
    logic       tx_vld_plan [8];

    // Observation of DUT-side pulses.
    logic [8:0] rx_q [$];
    int tx_ready_cnt = 0;
    int oe_cnt = 0;
    int oe_viol = 0;
    logic sda_oe_prev = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back({rx_first, rx_data});
        if (tx_ready) tx_ready_cnt <= tx_ready_cnt + 1;
        if (sda_oe) oe_cnt <= oe_cnt + 1;
        if (!rst && (sda_oe !== sda_oe_prev) && scl_bus) oe_viol <= oe_viol + 1;
        sda_oe_prev <= sda_oe;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Waits for SCL to float high; supplies late tx data if the target stretches.
    task automatic wait_scl_high();
        int n = 0;
        while (scl_bus !== 1'b1 && n < 400) begin
            @(posedge clk);
            n++;
            if (scl_oe) stretch_cnt++;
            if (stretch_cnt == 20 && !tx_valid) begin
                tx_data  = 8'h81;
                tx_valid = 1'b1;
            end
        end
        if (scl_bus !== 1'b1) check("scl_timeout", 32'(scl_bus), 32'd1);
    endtask

    task automatic i2c_start();
        wait_clk(2);
        m_sda_oe = 1'b0;
        wait_clk(Q);
        m_scl_oe = 1'b0;
        wait_scl_high();
        wait_clk(Q);
        m_sda_oe = 1'b1;
        wait_clk(Q);
        m_scl_oe = 1'b1;
        wait_clk(Q);
    endtask

    task automatic i2c_stop();
        wait_clk(2);
        m_sda_oe = 1'b1;
        wait_clk(Q);
        m_scl_oe = 1'b0;
        wait_scl_high();
        wait_clk(Q);
        m_sda_oe = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_bit(input logic b, output logic r);
        wait_clk(2);
        m_sda_oe = ~b;
        wait_clk(Q - 2);
        m_scl_oe = 1'b0;
        wait_scl_high();
        wait_clk(Q / 2);
        @(negedge clk);
        r = sda_bus;
        wait_clk(Q / 2);
        m_scl_oe = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], r);
        i2c_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic more,
                             input logic nv, input logic [7:0] nd);
        logic r;
        stretch_cnt = 0;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, r);
            d[i] = r;
        end
        tx_valid = nv;
        tx_data  = nd;
        i2c_bit(~more, r);
    endtask

    // One addressed transfer checked against the protocol-level expectation.
    task automatic do_xfer(input logic [6:0] addr, input logic rd, input int len, input logic stop);
        logic ack_exp, ack;
        logic [7:0] d, exp_b;
        int rx0, tr0, oe0, tr_exp, rx_exp;
        ack_exp = (addr == DUT_ADDR) && (addr != 7'd0);
        rx0 = rx_q.size();
        tr0 = tx_ready_cnt;
        oe0 = oe_cnt;
        tr_exp = 0;
        if (rd) begin
            tx_valid = tx_vld_plan[0];
            tx_data  = tx_dat_plan[0];
        end
        i2c_start();
        check("busy_after_start", 32'(busy), 32'd1);
        check("addressed_after_start", 32'(addressed), 32'd0);
        write_byte({addr, rd}, ack);
        check("addr_ack", 32'(ack), 32'(ack_exp));
        check("addressed_after_ack", 32'(addressed), 32'(ack_exp));
        if (ack_exp && !rd) begin
            for (int i = 0; i < len; i++) begin
                write_byte(wr_plan[i], ack);
                check("data_ack", 32'(ack), 32'd1);
            end
        end
        if (ack_exp && rd) begin
            for (int i = 0; i < len; i++) begin
                read_byte(d, (i < len - 1), (i + 1 < len) ? tx_vld_plan[i + 1] : 1'b0,
                          (i + 1 < len) ? tx_dat_plan[i + 1] : 8'h00);
                exp_b = tx_vld_plan[i] ? tx_dat_plan[i] : FILL;
                check("read_byte", 32'(d), 32'(exp_b));
                if (tx_vld_plan[i] || STRETCH) tr_exp++;
            end
        end
        if (stop) begin
            i2c_stop();
            wait_clk(8);
            check("busy_after_stop", 32'(busy), 32'd0);
            check("addressed_after_stop", 32'(addressed), 32'd0);
        end
        wait_clk(4);
        rx_exp = (ack_exp && !rd) ? len : 0;
        check("rx_count", 32'(rx_q.size() - rx0), 32'(rx_exp));
        for (int i = 0; i < rx_exp && (rx0 + i) < rx_q.size(); i++) begin
            check("rx_data", 32'(rx_q[rx0 + i][7:0]), 32'(wr_plan[i]));
            check("rx_first", 32'(rx_q[rx0 + i][8]), 32'(i == 0));
        end
        check("tx_ready_count", 32'(tx_ready_cnt - tr0), 32'(tr_exp));
        if (!ack_exp) check("no_sda_drive", 32'(oe_cnt - oe0), 32'd0);
        tx_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] addr_byte;
        logic r;
        int n;
        rst = 1'b1;
        m_scl_oe = 1'b0;
        m_sda_oe = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        wait_clk(5);
        @(negedge clk);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_scl_oe", 32'(scl_oe), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addressed", 32'(addressed), 32'd0);
        rst = 1'b0;
        wait_clk(5);

        wr_plan[0] = 8'h55; wr_plan[1] = 8'h55;
        do_xfer(DUT_ADDR, 1'b0, 2, 1'b1);
        wr_plan[0] = 8'hAA;
        do_xfer(7'h2C, 1'b0, 1, 1'b1);
        do_xfer(7'h00, 1'b0, 1, 1'b1);
        tx_dat_plan[0] = 8'hA5; tx_vld_plan[0] = 1'b1;
        tx_dat_plan[1] = 8'h3C; tx_vld_plan[1] = 1'b1;
        do_xfer(DUT_ADDR, 1'b1, 2, 1'b1);
        tx_dat_plan[0] = 8'h12; tx_vld_plan[0] = 1'b0;
        do_xfer(DUT_ADDR, 1'b1, 1, 1'b1);
        wr_plan[0] = 8'h11;
        do_xfer(DUT_ADDR, 1'b0, 1, 1'b0);
        tx_dat_plan[0] = 8'hC3; tx_vld_plan[0] = 1'b1;
        do_xfer(DUT_ADDR, 1'b1, 1, 1'b1);

        // Reset while the target is driving the address ACK.
        i2c_start();
        addr_byte = {DUT_ADDR, 1'b0};
        for (int i = 7; i >= 0; i--) i2c_bit(addr_byte[i], r);
        wait_clk(2);
        m_sda_oe = 1'b0;
        n = 0;
        while (!sda_oe && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ack_before_rst", 32'(sda_oe), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_addressed", 32'(addressed), 32'd0);
        check("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
        @(posedge clk);
        m_scl_oe = 1'b0;
        m_sda_oe = 1'b0;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(4);
        wr_plan[0] = 8'h5E;
        do_xfer(DUT_ADDR, 1'b0, 1, 1'b1);

        for (int t = 0; t < 10; t++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 2) != 0) ? DUT_ADDR : 7'($urandom_range(0, 127));
            for (int i = 0; i < 3; i++) begin
                wr_plan[i]     = 8'($urandom_range(0, 255));
                tx_dat_plan[i] = 8'($urandom_range(0, 255));
                tx_vld_plan[i] = ($urandom_range(0, 3) != 0);
            end
            do_xfer(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3), 1'b1);
        end

        check("sda_oe_change_while_scl_high", 32'(oe_viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
